// File: rtl/status_pkg.sv
// Shared status-valid definitions: default geometry and the per-slot state encoding
// used by both the producer-side status vector and the retirement controller.
package status_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int IDX_W_DEF = 4;

    typedef struct packed {
        logic valid;
        logic done;
    } slot_state_t;

    localparam slot_state_t SLOT_EMPTY = '{valid: 1'b0, done: 1'b0};

endpackage

// File: rtl/status_slot.sv
// One retirement slot: valid/done flops with allocate, complete and retire controls.
module status_slot
    import status_pkg::*;
(
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        set_alloc_i,
    input  logic        set_done_i,
    input  logic        clear_retire_i,
    output slot_state_t state_o
);

    slot_state_t state_q, state_d;

    // Allocation and retire never target the same slot in one cycle (tail != head when not full).
    always_comb begin
        state_d = state_q;
        if (clear_retire_i) begin
            state_d = SLOT_EMPTY;
        end
        if (set_alloc_i) begin
            state_d = '{valid: 1'b1, done: 1'b0};
        end else if (set_done_i) begin
            state_d.done = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/status_retire_ctrl.sv
// In-order retirement controller: allocates at the tail, accepts out-of-order completion,
// and drains the oldest completed entry over a valid/ready handshake.
module status_retire_ctrl
    import status_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             alloc_i,
    output logic             alloc_ready_o,
    output logic [IDX_W-1:0] alloc_idx_o,
    input  logic             done_i,
    input  logic [IDX_W-1:0] done_idx_i,
    output logic             retire_valid_o,
    output logic [IDX_W-1:0] retire_idx_o,
    input  logic             retire_ready_i,
    output logic [IDX_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_o
);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             err_q, err_d;

    logic [DEPTH-1:0] valid_w;
    logic [DEPTH-1:0] done_w;
    slot_state_t      slot_st [DEPTH];

    logic alloc_fire;
    logic done_ok;
    logic retire_fire;

    assign full_o         = (count_q == (IDX_W+1)'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign alloc_ready_o  = ~full_o;
    assign alloc_idx_o    = tail_q;
    assign retire_idx_o   = head_q;
    assign retire_valid_o = valid_w[head_q] & done_w[head_q];
    assign count_o        = count_q;
    assign err_o          = err_q;

    // A done is legal only on a valid, not-yet-done slot; anything else is a protocol error.
    assign alloc_fire  = alloc_i & alloc_ready_o;
    assign done_ok     = done_i & valid_w[done_idx_i] & ~done_w[done_idx_i];
    assign retire_fire = retire_valid_o & retire_ready_i;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        status_slot u_slot (
            .clk_i          (clk_i),
            .rsn_i          (rsn_i),
            .set_alloc_i    (alloc_fire && (tail_q == IDX_W'(g))),
            .set_done_i     (done_ok && (done_idx_i == IDX_W'(g))),
            .clear_retire_i (retire_fire && (head_q == IDX_W'(g))),
            .state_o        (slot_st[g])
        );
        assign valid_w[g] = slot_st[g].valid;
        assign done_w[g]  = slot_st[g].done;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        if (alloc_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (retire_fire) begin
            head_d = head_q + 1'b1;
        end
        case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (done_i && !done_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_status_retire_ctrl.sv
// Directed bench for status_retire_ctrl with hand-computed expectations.
module tb_status_retire_ctrl;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk_i = 1'b0;
    logic             rsn_i;
    logic             alloc_i;
    logic             alloc_ready_o;
    logic [IDX_W-1:0] alloc_idx_o;
    logic             done_i;
    logic [IDX_W-1:0] done_idx_i;
    logic             retire_valid_o;
    logic [IDX_W-1:0] retire_idx_o;
    logic             retire_ready_i;
    logic [IDX_W:0]   count_o;
    logic             full_o;
    logic             empty_o;
    logic             err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    status_retire_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_i          (clk_i),
        .rsn_i          (rsn_i),
        .alloc_i        (alloc_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_idx_o    (alloc_idx_o),
        .done_i         (done_i),
        .done_idx_i     (done_idx_i),
        .retire_valid_o (retire_valid_o),
        .retire_idx_o   (retire_idx_o),
        .retire_ready_i (retire_ready_i),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .err_o          (err_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_i        = 1'b0;
        done_i         = 1'b0;
        done_idx_i     = '0;
        retire_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rsn_i = 1'b0;
        #2;
        rsn_i = 1'b1;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ardy"},  int'(alloc_ready_o),  1);
        chk({tag, "_aidx"},  int'(alloc_idx_o),    0);
        chk({tag, "_rvld"},  int'(retire_valid_o), 0);
        chk({tag, "_ridx"},  int'(retire_idx_o),   0);
        chk({tag, "_count"}, int'(count_o),        0);
        chk({tag, "_full"},  int'(full_o),         0);
        chk({tag, "_empty"}, int'(empty_o),        1);
        chk({tag, "_err"},   int'(err_o),          0);
    endtask

    initial begin
        int exp_ret;
        int nret;

        idle_inputs();
        rsn_i = 1'b0;
        #3;
        chk_reset_outputs("rst");
        rsn_i = 1'b1;
        tick();
        chk_reset_outputs("post_rst");

        // Fill: 16 allocs, 17th dropped
        alloc_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_aidx", int'(alloc_idx_o), i);
            chk("fill_ardy", int'(alloc_ready_o), 1);
            tick();
        end
        chk("fill_full", int'(full_o), 1);
        chk("fill_count", int'(count_o), 16);
        chk("fill_ardy_full", int'(alloc_ready_o), 0);
        chk("fill_rvld", int'(retire_valid_o), 0);
        tick();
        alloc_i = 1'b0;
        chk("fill_drop_count", int'(count_o), 16);
        chk("fill_drop_err", int'(err_o), 0);
        chk("fill_drop_tail", int'(alloc_idx_o), 0);

        // Out-of-order completion
        do_reset();
        alloc_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        alloc_i = 1'b0;
        retire_ready_i = 1'b1;
        chk("ooo_count", int'(count_o), 4);
        done_i = 1'b1;
        done_idx_i = 4'd2; tick(); chk("ooo_rvld_a", int'(retire_valid_o), 0);
        done_idx_i = 4'd1; tick(); chk("ooo_rvld_b", int'(retire_valid_o), 0);
        done_idx_i = 4'd3; tick(); chk("ooo_rvld_c", int'(retire_valid_o), 0);
        done_idx_i = 4'd0; tick();
        done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ooo_rvld", int'(retire_valid_o), 1);
            chk("ooo_ridx", int'(retire_idx_o), i);
            tick();
        end
        chk("ooo_empty", int'(empty_o), 1);
        chk("ooo_rvld_end", int'(retire_valid_o), 0);
        chk("ooo_err", int'(err_o), 0);

        // Backpressure: head is slot 4
        retire_ready_i = 1'b0;
        alloc_i = 1'b1;
        chk("bp_aidx", int'(alloc_idx_o), 4);
        tick();
        alloc_i = 1'b0;
        done_i = 1'b1; done_idx_i = 4'd4;
        tick();
        done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvld", int'(retire_valid_o), 1);
            chk("bp_ridx", int'(retire_idx_o), 4);
            tick();
        end
        retire_ready_i = 1'b1;
        chk("bp_rvld_rdy", int'(retire_valid_o), 1);
        tick();
        chk("bp_empty", int'(empty_o), 1);
        chk("bp_rvld_after", int'(retire_valid_o), 0);
        chk("bp_ridx_after", int'(retire_idx_o), 5);

        // Wrap-around: head/tail at 5, 40 triplets
        exp_ret = 5;
        nret = 0;
        for (int k = 0; k < 42; k++) begin
            alloc_i    = (k < 40);
            done_i     = (k >= 1 && k <= 40);
            done_idx_i = IDX_W'((5 + k - 1) % DEPTH);
            if (k < 40) chk("wrap_aidx", int'(alloc_idx_o), (5 + k) % DEPTH);
            chk("wrap_cnt_le2", int'(count_o <= 2), 1);
            if (retire_valid_o) begin
                chk("wrap_ridx", int'(retire_idx_o), exp_ret % DEPTH);
                exp_ret++;
                nret++;
            end
            tick();
        end
        idle_inputs();
        chk("wrap_nret", nret, 40);
        chk("wrap_empty", int'(empty_o), 1);
        chk("wrap_head", int'(retire_idx_o), (5 + 40) % DEPTH);
        chk("wrap_err", int'(err_o), 0);

        // Errors
        do_reset();
        done_i = 1'b1; done_idx_i = 4'd5;
        tick();
        done_i = 1'b0;
        chk("err_invalid", int'(err_o), 1);
        tick(); tick();
        chk("err_sticky", int'(err_o), 1);
        do_reset();
        chk("err_rst", int'(err_o), 0);
        alloc_i = 1'b1; tick(); alloc_i = 1'b0;
        done_i = 1'b1; done_idx_i = 4'd0; tick();
        chk("err_first_done", int'(err_o), 0);
        tick();
        done_i = 1'b0;
        chk("err_double_done", int'(err_o), 1);
        do_reset();
        alloc_i = 1'b1; done_i = 1'b1; done_idx_i = 4'd0;
        tick();
        idle_inputs();
        chk("err_same_cycle", int'(err_o), 1);
        chk("err_same_cycle_rvld", int'(retire_valid_o), 0);

        // Reset mid-operation
        do_reset();
        alloc_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        alloc_i = 1'b0;
        done_i = 1'b1; done_idx_i = 4'd0;
        tick();
        done_i = 1'b0;
        chk("mid_count", int'(count_o), 7);
        chk("mid_rvld", int'(retire_valid_o), 1);
        rsn_i = 1'b0;
        #2;
        chk_reset_outputs("mid_async");
        rsn_i = 1'b1;
        tick();
        alloc_i = 1'b1;
        chk("mid_first_aidx", int'(alloc_idx_o), 0);
        tick();
        alloc_i = 1'b0;
        chk("mid_first_count", int'(count_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
